branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the 5-stage RV32 pipeline. It sits beside the IF-stage PC register and combines three structures: a direct-mapped branch target buffer (BTB), a saturating-counter history table and a return-address stack (RAS). Each cycle it predicts a next PC for the fetch address. It learns from control-transfer resolutions reported by the ID-stage branch unit, which replaces the current always-PC+4 fetch policy.

## Interface
- `ENTRIES`, 16: BTB/counter entries; power of two, ≥2; `IDX_W = log2(ENTRIES)`.
- `TAG_W`, 8: tag bits stored per entry.
- `CNT_W`, 2: counter width; ≥1.
- `RAS_DEPTH`, 4: return-stack entries; power of two, ≥2.
- `clk` in 1: clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_pc` in 32: current fetch PC.
- `if_valid` in 1: fetch slot valid. Used only for the lookup perf counter.
- `pred_taken` out 1: predict redirect.
- `pred_target` out 32: predicted next PC. Equals `if_pc + 4` when `pred_taken` = 0.
- `upd_valid` in 1: one resolved control transfer this cycle.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_type` in 2: `BP_BRANCH` = 0, `BP_JUMP` = 1, `BP_CALL` = 2, `BP_RET` = 3.
- `upd_taken` in 1: actual direction. Always 1 for types 1–3.
- `upd_target` in 32: actual target.
- `upd_mispredict` in 1: resolution disagreed with the prediction made for this instruction.
- `perf_lookups` out 32: count of cycles with `if_valid` = 1.
- `perf_mispred` out 32: count of updates with `upd_mispredict` = 1.

## Operation
- Address fields:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`
- Per-entry state: `valid`, `tag`, `target[31:0]`, `type[1:0]`, `cnt[CNT_W-1:0]`.
- Lookup is combinational from `if_pc`:
  - hit = `valid[idx]` and the stored tag matches.
  - `pred_taken` = hit and (`type` != `BP_BRANCH` or `cnt` MSB = 1).
  - `pred_target`:
    - if hit and `type` = `BP_RET` and RAS is non-empty: RAS top;
    - else if `pred_taken`: the entry's `target`;
    - else `if_pc + 4`.
- Update, on a rising edge with `upd_valid` = 1:
  - **Entry hit** (index and tag match): write `target` and `type`. For `BP_BRANCH`, `cnt` saturating-increments if taken and saturating-decrements if not; it never wraps.
  - **Entry miss, taken**: allocate (overwrite) the slot with valid = 1, the new tag/target/type, and `cnt` = 2^(CNT_W-1) (weakly taken).
  - **Entry miss, not-taken branch**: no allocation, no state change.
  - **`BP_CALL`**: push `upd_pc + 4` onto the RAS.
  - **`BP_RET`**: pop the RAS.
- RAS behaviour:
  - Circular buffer with a top pointer and an occupancy count saturating at `RAS_DEPTH`.
  - Push when full: overwrite the oldest entry; occupancy stays at `RAS_DEPTH`.
  - Pop when empty: no change.
  - A return predicted with the RAS empty falls back to the BTB `target`.
- Perf counters increment by 1 per qualifying cycle and wrap modulo 2^32.

## Timing
- Lookup has zero latency: prediction is valid in the same cycle `if_pc` is presented.
- Update latency is one cycle: state written at edge N is visible to lookups from cycle N onward.
  - A lookup and an update to the same index in the same cycle: the lookup sees the pre-update state.
- Exactly one update per cycle, so push and pop never coincide.
- Reset (`reset_n` = 0, asynchronous, effective immediately, including mid-operation):
  - all `valid` = 0;
  - all `cnt` = 0;
  - RAS pointer and count = 0;
  - both perf counters = 0.
- Outputs during and after reset until the first allocation: `pred_taken` = 0, `pred_target` = `if_pc + 4`.
- `upd_*` inputs are ignored while reset is asserted.

## Structure
- Add the `BP_BRANCH`/`BP_JUMP`/`BP_CALL`/`BP_RET` type encodings to the shared control-encoding define file, alongside the NPC op codes.
- Derived widths (`IDX_W`, RAS pointer width) are local parameters.
- The RAS is one sub-module, `bp_ras`, with ports:
  - push, pop, push_data;
  - top, empty;
  - RAS_DEPTH parameter.
- BTB arrays and counters stay in the top module.

## Test plan
- **Reset:** reset, then `if_pc` = 0x40 → `pred_taken` = 0, `pred_target` = 0x44, both perf counters 0.
- **Allocation and training:**
  - Update `BP_BRANCH` at 0x100, taken, target 0x80 → lookup 0x100 gives taken, 0x80.
  - Then two not-taken updates → not taken, `pred_target` = 0x104.
  - Then three taken updates → counter saturates at 3 with no wrap; the fourth not-taken update still predicts taken.
- **Not-taken miss:** update `BP_BRANCH` at 0x200, not taken, on an empty slot → lookup 0x200 stays not-taken, entry not allocated.
- **Aliasing (ENTRIES = 16):** allocate 0x100, then allocate 0x140 (same index, different tag) → lookup 0x100 misses, lookup 0x140 hits.
- **RAS:**
  - `BP_CALL` at 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH = 4), and a `BP_RET` entry at 0x300 → successive returns predict 0x54, 0x44, 0x34, 0x24, then the BTB target (empty fallback).
- **Async reset and perf counters:**
  - Assert `reset_n` mid-cycle after allocations → `pred_taken` drops before the next edge and all state is cleared.
  - Separately, 5 cycles with `if_valid` = 1 and 2 updates with `upd_mispredict` = 1 → `perf_lookups` = 5, `perf_mispred` = 2.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared encodings and helpers for the dynamic branch predictor.
//   bp_type_e : control-transfer type reported by the ID-stage branch unit
//   pc_plus4  : sequential fetch address
package branch_predictor_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BP_BRANCH = 2'd0,
    BP_JUMP   = 2'd1,
    BP_CALL   = 2'd2,
    BP_RET    = 2'd3
  } bp_type_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return XLEN'(pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, resolution-update and perf signals between the IF/ID stages
// and the branch predictor.
//   master : pipeline side (drives fetch PC and resolutions)
//   slave  : predictor side (drives prediction and perf counters)
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [31:0] if_pc;
  logic        if_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  bp_type_e    upd_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispred;

  modport master (
    output if_pc, if_valid, upd_valid, upd_pc, upd_type, upd_taken,
           upd_target, upd_mispredict,
    input  pred_taken, pred_target, perf_lookups, perf_mispred
  );

  modport slave (
    input  if_pc, if_valid, upd_valid, upd_pc, upd_type, upd_taken,
           upd_target, upd_mispredict,
    output pred_taken, pred_target, perf_lookups, perf_mispred
  );

endinterface

// File: rtl/bp_ras.sv
// Return-address stack: circular buffer with saturating occupancy.
//   clk, reset_n    : clock, async active-low reset
//   push, pop       : one operation per cycle (never both)
//   push_data       : return address to push
//   top, empty      : current top of stack and empty flag
module bp_ras #(
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned DEPTH_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]        stack_q [RAS_DEPTH];
  logic [PTR_W-1:0]   ptr_q;
  logic [DEPTH_W-1:0] occ_q;
  logic [PTR_W-1:0]   ptr_inc;

  // ptr_q addresses the current top; a push when full lands on the oldest slot
  assign ptr_inc = PTR_W'(ptr_q + PTR_W'(1));
  assign top     = stack_q[ptr_q];
  assign empty   = (occ_q == '0);

  // Pointer and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      occ_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_inc;
      if (occ_q != DEPTH_W'(RAS_DEPTH)) occ_q <= DEPTH_W'(occ_q + DEPTH_W'(1));
    end else if (pop && !empty) begin
      ptr_q <= PTR_W'(ptr_q - PTR_W'(1));
      occ_q <= DEPTH_W'(occ_q - DEPTH_W'(1));
    end
  end

  // Storage; contents beyond occupancy are never observed
  always_ff @(posedge clk) begin
    if (push) stack_q[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// counters plus a return-address stack.
//   clk, reset_n : clock, async active-low reset
//   bp (slave)   : if_pc/if_valid lookup, pred_taken/pred_target prediction
//                  (combinational), upd_* resolution, perf_* counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  bp_type_e           type_q   [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [31:0] lookups_q;
  logic [31:0] mispred_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_write;
  logic [CNT_W-1:0] cnt_nxt;

  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_top;
  logic        ras_empty;

  // Lookup
  assign lk_idx   = bp.if_pc[IDX_W+1:2];
  assign lk_tag   = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ((type_q[lk_idx] != BP_BRANCH) || cnt_q[lk_idx][CNT_W-1]);

  always_comb begin
    bp.pred_taken  = lk_taken;
    bp.pred_target = pc_plus4(bp.if_pc);
    if (lk_hit && (type_q[lk_idx] == BP_RET) && !ras_empty) begin
      bp.pred_target = ras_top;
    end else if (lk_taken) begin
      bp.pred_target = target_q[lk_idx];
    end
  end

  // Update decode: hits always write, misses allocate only when taken
  assign up_idx   = bp.upd_pc[IDX_W+1:2];
  assign up_tag   = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_write = bp.upd_valid && (up_hit || bp.upd_taken);

  // Counter next value; non-branch hits leave the counter alone
  always_comb begin
    cnt_nxt = cnt_q[up_idx];
    if (!up_hit) begin
      cnt_nxt = CNT_WEAK;
    end else if (bp.upd_type == BP_BRANCH) begin
      if (bp.upd_taken && (cnt_q[up_idx] != CNT_MAX)) begin
        cnt_nxt = CNT_W'(cnt_q[up_idx] + CNT_W'(1));
      end else if (!bp.upd_taken && (cnt_q[up_idx] != '0)) begin
        cnt_nxt = CNT_W'(cnt_q[up_idx] - CNT_W'(1));
      end
    end
  end

  // Valid bits and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else if (up_write) begin
      valid_q[up_idx] <= 1'b1;
      cnt_q[up_idx]   <= cnt_nxt;
    end
  end

  // Entry payload; qualified by valid_q so needs no reset
  always_ff @(posedge clk) begin
    if (up_write) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= bp.upd_target;
      type_q[up_idx]   <= bp.upd_type;
    end
  end

  // Performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (bp.if_valid) lookups_q <= 32'(lookups_q + 32'd1);
      if (bp.upd_valid && bp.upd_mispredict) mispred_q <= 32'(mispred_q + 32'd1);
    end
  end

  assign bp.perf_lookups = lookups_q;
  assign bp.perf_mispred = mispred_q;

  // Return-address stack
  assign ras_push = bp.upd_valid && (bp.upd_type == BP_CALL);
  assign ras_pop  = bp.upd_valid && (bp.upd_type == BP_RET);

  bp_ras #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4(bp.upd_pc)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule
